// File: rtl/vector_separation_if.sv
// Handshake bundle for the vector separation block: packed words in, unpacked A/B fields out.
// The block uses the slave modport; the environment (upstream source + downstream sink) uses master.
interface vector_separation_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_a;
    logic [1:0]  out_b;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_a, out_b
    );
endinterface

// File: rtl/vector_separation.sv
// Receive side of the packed 13-bit vector word: checks framing, tracks lock,
// unpacks good words into A/B fields and buffers them in a small output FIFO.
module vector_separation #(
    parameter int DEPTH  = 4,
    parameter int SYNC_N = 2,
    parameter int LOSS_N = 3,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_separation_if.slave   link,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(SYNC_N + 1);
    localparam int BW = $clog2(LOSS_N + 1);
    localparam logic [GW-1:0] SYNC_LAST = GW'(SYNC_N - 1);
    localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_N - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t          state;
    logic [GW-1:0]   good_run;
    logic [BW-1:0]   bad_run;

    logic [3:0]      mem_a [DEPTH];
    logic [1:0]      mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            pend;
    logic [3:0]      pend_a;
    logic [1:0]      pend_b;

    logic            accept;
    logic            pop;
    logic            good;
    logic [3:0]      word_a;
    logic [1:0]      word_b;
    logic            pend_next;
    logic [CW-1:0]   count_next;
    logic [CW:0]     occ_next;

    assign accept = link.in_valid && link.in_ready;
    assign pop    = link.out_valid && link.out_ready;
    assign good   = (link.in_word[12:9] == 4'b0001) && (link.in_word[4:3] == 2'b00)
                    && !link.in_word[0];
    assign word_a = {link.in_word[2], link.in_word[6], link.in_word[8], link.in_word[7]};
    assign word_b = {link.in_word[1], link.in_word[5]};

    // A good word in LOCK is staged for one cycle before it lands in the FIFO, so the
    // staged entry must be counted against capacity when deciding in_ready.
    assign pend_next  = accept && good && (state == LOCK);
    assign count_next = count + CW'(pend) - CW'(pop);
    assign occ_next   = {1'b0, count_next} + (CW + 1)'(pend_next);

    assign link.out_valid = (count != '0);
    assign link.out_a     = mem_a[rd_ptr];
    assign link.out_b     = mem_b[rd_ptr];

    // Framing state machine: HUNT discards everything until SYNC_N good words in a row,
    // LOCK forwards good words and falls back after LOSS_N bad words in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            good_run  <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                case (state)
                    HUNT: begin
                        if (!good) begin
                            good_run <= '0;
                        end else if (good_run == SYNC_LAST) begin
                            state    <= LOCK;
                            locked   <= 1'b1;
                            good_run <= '0;
                            bad_run  <= '0;
                        end else begin
                            good_run <= good_run + GW'(1);
                        end
                    end
                    LOCK: begin
                        if (good) begin
                            bad_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            if (bad_run == LOSS_LAST) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                bad_run <= bad_run + BW'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // Output FIFO with a one-entry staging register in front of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pend          <= 1'b0;
            pend_a        <= '0;
            pend_b        <= '0;
            link.in_ready <= 1'b1;
        end else begin
            pend   <= pend_next;
            pend_a <= word_a;
            pend_b <= word_b;
            if (pend) begin
                mem_a[wr_ptr] <= pend_a;
                mem_b[wr_ptr] <= pend_b;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count         <= count_next;
            link.in_ready <= (occ_next < (CW + 1)'(DEPTH));
        end
    end
endmodule

// File: tb/tb_vector_separation.sv
// Directed, table-driven bench for vector_separation: framing lock, error counting,
// backpressure, error-counter saturation and mid-stream reset.
module tb_vector_separation;
    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    int         total_cnt;
    int         bad_cnt;

    vector_separation_if link ();

    vector_separation #(
        .DEPTH (4),
        .SYNC_N(2),
        .LOSS_N(3),
        .ERR_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .link     (link),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] word;
        logic        deliver;
        logic [3:0]  a;
        logic [1:0]  b;
        logic        lock;
        logic        pulse;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [17];
    vec_t rvecs [3];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for in_ready, presents one word and returns just after the accepting edge.
    task automatic applyStimulus(input logic [12:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!link.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!link.in_ready) begin
            total_cnt++;
            bad_cnt++;
            $display("[TB] FAIL in_ready timeout: got 0 expected 1");
        end
        link.in_valid = 1'b1;
        link.in_word  = w;
        @(posedge clk);
        #1;
        link.in_valid = 1'b0;
    endtask

    task automatic applyVector(input vec_t v, input string tag);
        applyStimulus(v.word);
        checkOutput({tag, " locked"}, 32'(locked), 32'(v.lock));
        checkOutput({tag, " err_pulse"}, 32'(err_pulse), 32'(v.pulse));
        checkOutput({tag, " err_cnt"}, 32'(err_cnt), 32'(v.cnt));
        @(posedge clk);
        #1;
        checkOutput({tag, " out_valid"}, 32'(link.out_valid), 32'(v.deliver));
        if (v.deliver) begin
            checkOutput({tag, " out_a"}, 32'(link.out_a), 32'(v.a));
            checkOutput({tag, " out_b"}, 32'(link.out_b), 32'(v.b));
        end
        checkOutput({tag, " pulse_off"}, 32'(err_pulse), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [12:0] burst_w [4];
        logic [3:0]  burst_a [4];
        logic [1:0]  burst_b [4];
        logic [3:0]  held_a;
        logic [1:0]  held_b;
        logic        will_accept;
        int          accepted;
        int          popped;
        int          exp_cnt;

        total_cnt = 0;
        bad_cnt   = 0;

        vecs[0]  = '{13'h0386, 1'b0, 4'h0,    2'h0,  1'b0, 1'b0, 8'd0};
        vecs[1]  = '{13'h0386, 1'b0, 4'h0,    2'h0,  1'b1, 1'b0, 8'd0};
        vecs[2]  = '{13'h0386, 1'b1, 4'b1011, 2'b10, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{13'h0387, 1'b0, 4'h0,    2'h0,  1'b1, 1'b1, 8'd1};
        vecs[4]  = '{13'h0200, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{13'h03E6, 1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{13'h0260, 1'b1, 4'b0100, 2'b01, 1'b1, 1'b0, 8'd1};
        vecs[7]  = '{13'h0586, 1'b0, 4'h0,    2'h0,  1'b1, 1'b1, 8'd2};
        vecs[8]  = '{13'h0208, 1'b0, 4'h0,    2'h0,  1'b1, 1'b1, 8'd3};
        vecs[9]  = '{13'h0387, 1'b0, 4'h0,    2'h0,  1'b0, 1'b1, 8'd4};
        vecs[10] = '{13'h0386, 1'b0, 4'h0,    2'h0,  1'b0, 1'b0, 8'd4};
        vecs[11] = '{13'h0386, 1'b0, 4'h0,    2'h0,  1'b1, 1'b0, 8'd4};
        vecs[12] = '{13'h0386, 1'b1, 4'b1011, 2'b10, 1'b1, 1'b0, 8'd4};
        vecs[13] = '{13'h0387, 1'b0, 4'h0,    2'h0,  1'b1, 1'b1, 8'd5};
        vecs[14] = '{13'h0387, 1'b0, 4'h0,    2'h0,  1'b1, 1'b1, 8'd6};
        vecs[15] = '{13'h0260, 1'b1, 4'b0100, 2'b01, 1'b1, 1'b0, 8'd6};
        vecs[16] = '{13'h0387, 1'b0, 4'h0,    2'h0,  1'b1, 1'b1, 8'd7};

        rvecs[0] = '{13'h0386, 1'b0, 4'h0,    2'h0,  1'b0, 1'b0, 8'd0};
        rvecs[1] = '{13'h0386, 1'b0, 4'h0,    2'h0,  1'b1, 1'b0, 8'd0};
        rvecs[2] = '{13'h0386, 1'b1, 4'b1011, 2'b10, 1'b1, 1'b0, 8'd0};

        burst_w = '{13'h0200, 13'h03E6, 13'h0260, 13'h0386};
        burst_a = '{4'b0000, 4'b1111, 4'b0100, 4'b1011};
        burst_b = '{2'b00, 2'b11, 2'b01, 2'b10};

        link.in_valid  = 1'b0;
        link.in_word   = '0;
        link.out_ready = 1'b1;
        rst_n          = 1'b0;
        #12;
        checkOutput("reset out_valid", 32'(link.out_valid), 32'h0);
        checkOutput("reset out_a", 32'(link.out_a), 32'h0);
        checkOutput("reset out_b", 32'(link.out_b), 32'h0);
        checkOutput("reset in_ready", 32'(link.in_ready), 32'h1);
        checkOutput("reset locked", 32'(locked), 32'h0);
        checkOutput("reset err_pulse", 32'(err_pulse), 32'h0);
        checkOutput("reset err_cnt", 32'(err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: with the sink stalled exactly DEPTH words fit, then drain in order.
        link.out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            link.in_valid = 1'b1;
            link.in_word  = burst_w[accepted % 4];
            will_accept   = link.in_ready;
            @(posedge clk);
            if (will_accept) accepted++;
        end
        #1;
        link.in_valid = 1'b0;
        checkOutput("bp accepted", 32'(accepted), 32'd4);
        checkOutput("bp in_ready", 32'(link.in_ready), 32'h0);
        checkOutput("bp out_valid", 32'(link.out_valid), 32'h1);
        held_a = link.out_a;
        held_b = link.out_b;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp hold a", 32'(link.out_a), 32'(held_a));
        checkOutput("bp hold b", 32'(link.out_b), 32'(held_b));
        @(negedge clk);
        link.out_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 20; c++) begin
            if (link.out_valid) begin
                if (popped < 4) begin
                    checkOutput($sformatf("drain%0d a", popped), 32'(link.out_a), 32'(burst_a[popped]));
                    checkOutput($sformatf("drain%0d b", popped), 32'(link.out_b), 32'(burst_b[popped]));
                end
                popped++;
            end
            @(negedge clk);
        end
        checkOutput("drain count", 32'(popped), 32'd4);
        checkOutput("drain in_ready", 32'(link.in_ready), 32'h1);

        // Saturation: keep bad runs short enough to stay locked while err_cnt climbs to all-ones.
        exp_cnt = 7;
        while (exp_cnt < 255) begin
            applyStimulus(13'h0386);
            applyStimulus(13'h0387);
            exp_cnt++;
            if (exp_cnt < 255) begin
                applyStimulus(13'h0387);
                exp_cnt++;
            end
        end
        checkOutput("sat err_cnt", 32'(err_cnt), 32'hFF);
        checkOutput("sat locked", 32'(locked), 32'h1);
        applyStimulus(13'h0386);
        applyStimulus(13'h0387);
        checkOutput("sat extra err_cnt", 32'(err_cnt), 32'hFF);
        checkOutput("sat extra err_pulse", 32'(err_pulse), 32'h1);
        checkOutput("sat extra locked", 32'(locked), 32'h1);

        // Mid-stream reset with three entries buffered behind a stalled sink.
        link.out_ready = 1'b0;
        applyStimulus(13'h0200);
        applyStimulus(13'h03E6);
        applyStimulus(13'h0260);
        @(posedge clk);
        #1;
        checkOutput("pre-reset out_valid", 32'(link.out_valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 32'(link.out_valid), 32'h0);
        checkOutput("midreset locked", 32'(locked), 32'h0);
        checkOutput("midreset err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("midreset in_ready", 32'(link.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        link.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyVector(rvecs[i], $sformatf("rvec%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
